// File: rtl/rtr_output_credit_sched.sv
// Credit tracker and round-robin VC scheduler for one router output port.
// Each VC has one credit counter; a grant is given only to a requesting VC that holds credit.
module rtr_output_credit_sched #(
    parameter  int num_vcs         = 4,
    parameter  int buffer_size     = 8,
    localparam int vc_idx_width    = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int flow_ctrl_width = (num_vcs > 1) ? 1 + vc_idx_width : 1,
    localparam int cred_width      = $clog2(buffer_size + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [flow_ctrl_width-1:0] flow_ctrl_in,
    input  logic [num_vcs-1:0]         req_ovc,
    output logic [num_vcs-1:0]         gnt_ovc,
    output logic                       gnt_valid,
    output logic [num_vcs-1:0]         cred_avail_ovc,
    output logic [num_vcs-1:0]         empty_ovc,
    output logic                       error_ovf
);

    localparam logic [cred_width-1:0]   cnt_full = cred_width'(buffer_size);
    localparam logic [vc_idx_width-1:0] last_vc  = vc_idx_width'(num_vcs - 1);

    logic                    cred_valid_reg;
    logic [vc_idx_width-1:0] cred_idx_reg;
    logic [vc_idx_width-1:0] ptr_reg;
    logic                    error_ovf_reg;
    logic [num_vcs-1:0]      elig;
    logic [num_vcs-1:0]      gnt_next;
    logic [vc_idx_width-1:0] win_idx;
    logic                    idx_ok;
    logic [num_vcs-1:0]      ovf_vec;

    // With a single VC there is no index field: every credit targets VC 0.
    generate
        if (num_vcs > 1) begin : g_idx
            always_ff @(posedge clk) begin
                if (reset) begin
                    cred_valid_reg <= 1'b0;
                    cred_idx_reg   <= '0;
                end else begin
                    cred_valid_reg <= flow_ctrl_in[0];
                    cred_idx_reg   <= flow_ctrl_in[flow_ctrl_width-1:1];
                end
            end
        end else begin : g_noidx
            always_ff @(posedge clk) begin
                if (reset) begin
                    cred_valid_reg <= 1'b0;
                end else begin
                    cred_valid_reg <= flow_ctrl_in[0];
                end
            end
            assign cred_idx_reg = '0;
        end
    endgenerate

    assign idx_ok = (int'(cred_idx_reg) < num_vcs);
    assign elig   = req_ovc & cred_avail_ovc;

    // First eligible VC at or after the pointer, wrapping around.
    always_comb begin
        int v;
        v        = 0;
        gnt_next = '0;
        win_idx  = '0;
        for (int off = 0; off < num_vcs; off++) begin
            v = int'(ptr_reg) + off;
            if (v >= num_vcs) v = v - num_vcs;
            if (gnt_next == '0 && elig[v]) begin
                gnt_next[v] = 1'b1;
                win_idx     = vc_idx_width'(v);
            end
        end
    end

    assign gnt_ovc   = gnt_next;
    assign gnt_valid = |gnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (gnt_valid) begin
            ptr_reg <= (win_idx == last_vc) ? '0 : win_idx + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < num_vcs; gi++) begin : g_vc
            logic [cred_width-1:0] cnt_reg;
            logic                  ret;

            assign ret = cred_valid_reg && idx_ok && (int'(cred_idx_reg) == gi);

            // Simultaneous grant and return cancel; a lone return on a full counter saturates.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= cnt_full;
                end else if (ret && !gnt_next[gi]) begin
                    if (cnt_reg != cnt_full) cnt_reg <= cnt_reg + 1'b1;
                end else if (gnt_next[gi] && !ret) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end

            assign ovf_vec[gi]        = ret && !gnt_next[gi] && (cnt_reg == cnt_full);
            assign cred_avail_ovc[gi] = (cnt_reg != '0);
            assign empty_ovc[gi]      = (cnt_reg == cnt_full);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            error_ovf_reg <= 1'b0;
        end else if ((|ovf_vec) || (cred_valid_reg && !idx_ok)) begin
            error_ovf_reg <= 1'b1;
        end
    end

    assign error_ovf = error_ovf_reg;

endmodule

// File: tb/tb_rtr_output_credit_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a credit/round-robin model.
module tb_rtr_output_credit_sched;

    logic       clk;
    logic       reset;
    logic [2:0] flow_ctrl_in;
    logic [3:0] req_ovc;
    logic [3:0] gnt_ovc;
    logic       gnt_valid;
    logic [3:0] cred_avail_ovc;
    logic [3:0] empty_ovc;
    logic       error_ovf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_cnt [4];
    int         m_ptr;
    bit         m_pv;
    int         m_pi;
    bit         m_err;
    bit         cur_rst;
    logic [3:0] cur_req;
    bit         cur_v;
    int         cur_i;

    rtr_output_credit_sched #(.num_vcs(4), .buffer_size(8)) dut (
        .clk(clk),
        .reset(reset),
        .flow_ctrl_in(flow_ctrl_in),
        .req_ovc(req_ovc),
        .gnt_ovc(gnt_ovc),
        .gnt_valid(gnt_valid),
        .cred_avail_ovc(cred_avail_ovc),
        .empty_ovc(empty_ovc),
        .error_ovf(error_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_gnt();
        logic [3:0] g;
        g = '0;
        for (int off = 0; off < 4; off++) begin
            int v;
            v = (m_ptr + off) % 4;
            if (g == '0 && cur_req[v] && m_cnt[v] > 0) g[v] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [3:0] m_avail();
        logic [3:0] a;
        for (int v = 0; v < 4; v++) a[v] = (m_cnt[v] != 0);
        return a;
    endfunction

    function automatic logic [3:0] m_empty();
        logic [3:0] e;
        for (int v = 0; v < 4; v++) e[v] = (m_cnt[v] == 8);
        return e;
    endfunction

    task automatic drive(input bit rst, input logic [3:0] req, input bit cv, input int ci);
        @(negedge clk);
        reset        = rst;
        req_ovc      = req;
        flow_ctrl_in = {2'(ci), cv};
        cur_rst      = rst;
        cur_req      = req;
        cur_v        = cv;
        cur_i        = ci;
        #1;
    endtask

    task automatic tick();
        logic [3:0] g;
        g = m_gnt();
        @(posedge clk);
        if (cur_rst) begin
            for (int v = 0; v < 4; v++) m_cnt[v] = 8;
            m_ptr = 0;
            m_pv  = 0;
            m_pi  = 0;
            m_err = 0;
        end else begin
            for (int v = 0; v < 4; v++) begin
                bit ret;
                ret = m_pv && (m_pi == v);
                if (ret && !g[v]) begin
                    if (m_cnt[v] == 8) m_err = 1;
                    else m_cnt[v] = m_cnt[v] + 1;
                end else if (g[v] && !ret) begin
                    m_cnt[v] = m_cnt[v] - 1;
                end
                if (g[v]) m_ptr = (v + 1) % 4;
            end
            m_pv = cur_v;
            m_pi = cur_i;
        end
    endtask

    task automatic do_reset();
        drive(1, 4'b0000, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 4'b0000, 0, 0);
        total++; if (cred_avail_ovc !== 4'b1111) begin bad++; $display("FAIL reset_avail: got %b want 1111", cred_avail_ovc); end
        total++; if (empty_ovc !== 4'b1111) begin bad++; $display("FAIL reset_empty: got %b want 1111", empty_ovc); end
        total++; if (gnt_ovc !== 4'b0000 || gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b/%b want 0000/0", gnt_ovc, gnt_valid); end
        total++; if (error_ovf !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", error_ovf); end
        tick();
    endtask

    task automatic test_single_vc_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 4'b1000, 0, 0);
            total++; if (gnt_ovc !== 4'b1000 || gnt_valid !== 1'b1) begin bad++; $display("FAIL drain_gnt[%0d]: got %b want 1000", i, gnt_ovc); end
            tick();
        end
        drive(0, 4'b1000, 0, 0);
        total++; if (gnt_ovc !== 4'b0000 || gnt_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_gnt: got %b want 0000", gnt_ovc); end
        total++; if (cred_avail_ovc !== 4'b0111) begin bad++; $display("FAIL drain_avail: got %b want 0111", cred_avail_ovc); end
        tick();
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [3:0] exp;
            exp = 4'b0001 << (i % 4);
            drive(0, 4'b1111, 0, 0);
            total++; if (gnt_ovc !== exp) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_ovc, exp); end
            tick();
        end
        drive(0, 4'b0000, 0, 0);
        total++; if (cred_avail_ovc !== 4'b1111 || empty_ovc !== 4'b0000) begin bad++; $display("FAIL rr_state: got avail %b empty %b want 1111 0000", cred_avail_ovc, empty_ovc); end
        tick();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 4'b0001, 0, 0);
            if (gnt_ovc == 4'b0001) n++;
            tick();
        end
        total++; if (n != 6) begin bad++; $display("FAIL rr_vc0_remaining: got %0d want 6", n); end
    endtask

    task automatic test_credit_return();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 4'b0010, 0, 0);
            tick();
        end
        drive(0, 4'b0010, 1, 1);
        total++; if (gnt_ovc !== 4'b0000 || cred_avail_ovc[1] !== 1'b0) begin bad++; $display("FAIL cret_before: got gnt %b avail %b want 0000 x0xx", gnt_ovc, cred_avail_ovc); end
        tick();
        drive(0, 4'b0010, 0, 0);
        total++; if (gnt_ovc !== 4'b0000 || cred_avail_ovc[1] !== 1'b0) begin bad++; $display("FAIL cret_registered: got gnt %b avail %b want 0000 x0xx", gnt_ovc, cred_avail_ovc); end
        tick();
        drive(0, 4'b0010, 0, 0);
        total++; if (gnt_ovc !== 4'b0010 || cred_avail_ovc[1] !== 1'b1) begin bad++; $display("FAIL cret_applied: got gnt %b avail %b want 0010 x1xx", gnt_ovc, cred_avail_ovc); end
        tick();
    endtask

    task automatic test_same_edge();
        int n;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b0100, 0, 0);
            tick();
        end
        drive(0, 4'b0000, 1, 2);
        tick();
        drive(0, 4'b0100, 0, 0);
        total++; if (gnt_ovc !== 4'b0100) begin bad++; $display("FAIL same_edge_gnt: got %b want 0100", gnt_ovc); end
        tick();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 4'b0100, 0, 0);
            if (gnt_ovc == 4'b0100) n++;
            tick();
        end
        total++; if (n != 3) begin bad++; $display("FAIL same_edge_count: got %0d want 3", n); end
        total++; if (error_ovf !== 1'b0) begin bad++; $display("FAIL same_edge_err: got %b want 0", error_ovf); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(0, 4'b0000, 1, 0);
        tick();
        drive(0, 4'b0000, 0, 0);
        total++; if (error_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", error_ovf); end
        tick();
        drive(0, 4'b0000, 0, 0);
        total++; if (error_ovf !== 1'b1 || empty_ovc[0] !== 1'b1) begin bad++; $display("FAIL ovf_set: got err %b empty %b want 1 xxx1", error_ovf, empty_ovc); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'($urandom_range(0, 15)), 0, 0);
            total++; if (error_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky[%0d]: got %b want 1", i, error_ovf); end
            tick();
        end
        do_reset();
        drive(0, 4'b0000, 0, 0);
        total++; if (error_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared: got %b want 0", error_ovf); end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b1111, 0, 0);
            tick();
        end
        drive(0, 4'b0000, 1, 0);
        tick();
        drive(1, 4'b0000, 0, 0);
        tick();
        drive(0, 4'b1111, 0, 0);
        total++; if (cred_avail_ovc !== 4'b1111 || empty_ovc !== 4'b1111) begin bad++; $display("FAIL midreset_state: got avail %b empty %b want 1111 1111", cred_avail_ovc, empty_ovc); end
        total++; if (gnt_ovc !== 4'b0001) begin bad++; $display("FAIL midreset_ptr: got %b want 0001", gnt_ovc); end
        tick();
        drive(0, 4'b0000, 0, 0);
        total++; if (empty_ovc !== 4'b1110 || error_ovf !== 1'b0) begin bad++; $display("FAIL midreset_discard: got empty %b err %b want 1110 0", empty_ovc, error_ovf); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit         rst, cv;
            int         ci;
            logic [3:0] req;
            rst = ($urandom_range(0, 99) == 0);
            req = 4'($urandom_range(0, 15));
            cv  = ($urandom_range(0, 2) == 0);
            ci  = $urandom_range(0, 3);
            if ($urandom_range(0, 19) != 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_cnt[(ci + k) % 4] < 8) begin
                        ci = (ci + k) % 4;
                        break;
                    end
                end
            end
            drive(rst, req, cv, ci);
            total++; if (gnt_ovc !== m_gnt() || gnt_valid !== (|m_gnt())) begin bad++; $display("FAIL rand_gnt[%0d]: got %b/%b want %b", i, gnt_ovc, gnt_valid, m_gnt()); end
            total++; if (cred_avail_ovc !== m_avail()) begin bad++; $display("FAIL rand_avail[%0d]: got %b want %b", i, cred_avail_ovc, m_avail()); end
            total++; if (empty_ovc !== m_empty()) begin bad++; $display("FAIL rand_empty[%0d]: got %b want %b", i, empty_ovc, m_empty()); end
            total++; if (error_ovf !== m_err) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", i, error_ovf, m_err); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        req_ovc      = '0;
        flow_ctrl_in = '0;
        for (int v = 0; v < 4; v++) m_cnt[v] = 8;
        m_ptr   = 0;
        m_pv    = 0;
        m_pi    = 0;
        m_err   = 0;
        cur_rst = 1;
        cur_req = '0;
        cur_v   = 0;
        cur_i   = 0;
        test_reset();
        test_single_vc_drain();
        test_round_robin();
        test_credit_return();
        test_same_edge();
        test_overflow();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
